// File: rtl/instr_cache_assoc_if.sv
// Bus bundle for instr_cache_assoc.
//
// Fetch side (one lane per read port):
//   i_address[p]  byte address for port p
//   i_read[p]     port p requests a word this cycle
//   o_instr[p]    fetched word, 0 unless o_hit[p]
//   o_hit[p]      o_instr[p] is valid this cycle (combinational lookup)
//   i_flush       invalidate every line
// Refill side:
//   o_mem_address line-aligned refill address
//   o_mem_read    refill request
//   i_mem_data    refill line, word w at bits [32w+31:32w]
//   i_mem_ready   one-cycle strobe qualifying i_mem_data
// Status:
//   o_miss_count  saturating count of refills started
//   o_fetch_state refill FSM state (0 = IDLE, 1 = FETCH)
//
// Refill handshake: the cache raises o_mem_read with a stable
// o_mem_address and holds both unchanged until the memory answers with a
// single-cycle i_mem_ready pulse carrying the whole line on i_mem_data.
// The transfer completes on that rising edge; i_mem_ready outside a
// pending request is ignored.
interface instr_cache_assoc_if #(
  parameter int PORTS      = 2,
  parameter int LINE_WORDS = 8
);
  logic [PORTS-1:0][31:0]    i_address;
  logic [PORTS-1:0]          i_read;
  logic [PORTS-1:0][31:0]    o_instr;
  logic [PORTS-1:0]          o_hit;
  logic                      i_flush;
  logic [31:0]               o_mem_address;
  logic                      o_mem_read;
  logic [32*LINE_WORDS-1:0]  i_mem_data;
  logic                      i_mem_ready;
  logic [31:0]               o_miss_count;
  logic                      o_fetch_state;

  modport slave (
    input  i_address, i_read, i_flush, i_mem_data, i_mem_ready,
    output o_instr, o_hit, o_mem_address, o_mem_read, o_miss_count,
           o_fetch_state
  );

  modport master (
    output i_address, i_read, i_flush, i_mem_data, i_mem_ready,
    input  o_instr, o_hit, o_mem_address, o_mem_read, o_miss_count,
           o_fetch_state
  );
endinterface

// File: rtl/instr_cache_assoc.sv
// Multi-port set-associative instruction cache with a single refill engine.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous active-low reset
//   bus    instr_cache_assoc_if.slave (fetch lanes, refill bus, status)
//
// Lookups on every port are combinational. One refill is in flight at a
// time; the lowest-numbered missing port picks the line. Victim is the
// lowest invalid way, otherwise the per-set round-robin pointer.
module instr_cache_assoc #(
  parameter int SETS       = 8,
  parameter int WAYS       = 2,
  parameter int PORTS      = 2,
  parameter int LINE_WORDS = 8
) (
  input logic                clock,
  input logic                reset,
  instr_cache_assoc_if.slave bus
);
  localparam int OFF       = $clog2(LINE_WORDS) + 2;
  localparam int SB        = $clog2(SETS);
  localparam int TAG       = 32 - OFF - SB;
  localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_BITS = 32 * LINE_WORDS;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;
  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [TAG-1:0]            tag_q  [SETS][WAYS];
  logic [LINE_BITS-1:0]      data_q [SETS][WAYS];
  logic [WB-1:0]             rr_q   [SETS];
  logic [31:0]               line_q;
  logic [31:0]               miss_count_q;
  // Set when a flush lands while a refill is pending: the line that
  // eventually returns belongs to the pre-flush cache and must be dropped.
  logic                      discard_q;

  logic [PORTS-1:0]          hit;
  logic [PORTS-1:0][31:0]    instr;
  logic [PORTS-1:0]          miss;
  logic                      any_miss;
  logic [31:0]               win_line;
  logic [SB-1:0]             fill_set;
  logic [WB-1:0]             victim;
  logic                      victim_free;
  logic                      fill_en;
  logic                      unused_addr_bits;

  // Raw tag match per port; a tag lives in at most one way of a set.
  always_comb begin
    hit   = '0;
    instr = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[bus.i_address[p][OFF+SB-1:OFF]][w] &&
            tag_q[bus.i_address[p][OFF+SB-1:OFF]][w] == bus.i_address[p][31:OFF+SB]) begin
          hit[p]   = 1'b1;
          instr[p] = data_q[bus.i_address[p][OFF+SB-1:OFF]][w]
                       [{bus.i_address[p][OFF-1:2], 5'b0} +: 32];
        end
      end
    end
  end

  // Qualify with read and reset; reset forces every lane quiet.
  always_comb begin
    bus.o_hit   = '0;
    bus.o_instr = '0;
    miss        = '0;
    if (reset) begin
      for (int p = 0; p < PORTS; p++) begin
        if (bus.i_read[p]) begin
          if (hit[p]) begin
            bus.o_hit[p]   = 1'b1;
            bus.o_instr[p] = instr[p];
          end else begin
            miss[p] = 1'b1;
          end
        end
      end
    end
  end

  // Lowest-index missing port wins; walk downward so it is written last.
  always_comb begin
    any_miss = 1'b0;
    win_line = '0;
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (miss[p]) begin
        any_miss = 1'b1;
        win_line = {bus.i_address[p][31:OFF], {OFF{1'b0}}};
      end
    end
  end

  // Victim for the pending line: lowest invalid way, else round-robin.
  always_comb begin
    fill_set    = line_q[OFF+SB-1:OFF];
    victim      = rr_q[fill_set];
    victim_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_set][w]) begin
        victim      = WB'(w);
        victim_free = 1'b1;
      end
    end
  end

  assign fill_en = (state_q == FETCH) && bus.i_mem_ready &&
                   !bus.i_flush && !discard_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_miss) state_d = FETCH;
      FETCH:   if (bus.i_mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_q       <= '0;
      miss_count_q <= '0;
      discard_q    <= 1'b0;
      valid_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_miss) begin
        line_q    <= win_line;
        discard_q <= 1'b0;
        if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
      end else if (state_q == FETCH && bus.i_flush) begin
        discard_q <= 1'b1;
      end
      if (fill_en) begin
        valid_q[fill_set][victim] <= 1'b1;
        tag_q[fill_set][victim]   <= line_q[31:OFF+SB];
        data_q[fill_set][victim]  <= bus.i_mem_data;
        if (!victim_free) begin
          rr_q[fill_set] <= (rr_q[fill_set] == WB'(WAYS - 1)) ? '0 : rr_q[fill_set] + 1'b1;
        end
      end
      // Placed last so a flush overrides a same-edge fill.
      if (bus.i_flush) begin
        valid_q <= '0;
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end
    end
  end

  assign bus.o_mem_read    = (state_q == FETCH);
  assign bus.o_mem_address = (state_q == FETCH) ? line_q : 32'd0;
  assign bus.o_miss_count  = miss_count_q;
  assign bus.o_fetch_state = state_q;

  always_comb begin
    unused_addr_bits = 1'b0;
    for (int p = 0; p < PORTS; p++) unused_addr_bits = unused_addr_bits ^ (^bus.i_address[p][1:0]);
  end
endmodule

// File: tb/tb_instr_cache_assoc.sv
module tb_instr_cache_assoc;
  localparam int SETS       = 8;
  localparam int WAYS       = 2;
  localparam int PORTS      = 2;
  localparam int LINE_WORDS = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  instr_cache_assoc_if #(.PORTS(PORTS), .LINE_WORDS(LINE_WORDS)) bus ();

  instr_cache_assoc #(
    .SETS(SETS), .WAYS(WAYS), .PORTS(PORTS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h104) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [32*LINE_WORDS-1:0] mem_line(input logic [31:0] line);
    logic [32*LINE_WORDS-1:0] d;
    for (int w = 0; w < LINE_WORDS; w++) d[32*w +: 32] = mem_word(line + 32'(4 * w));
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    check(tag, obs);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; outputs are sampled there (+1).
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic lookup(input int p, input logic [31:0] addr, input logic exp_hit);
    bus.i_read[p]    = 1'b1;
    bus.i_address[p] = addr;
    #1;
    exp_q.push_back({31'b0, exp_hit});
    exp_q.push_back(exp_hit ? mem_word(addr) : 32'd0);
    check($sformatf("hit p%0d %h", p, addr), {31'b0, bus.o_hit[p]});
    check($sformatf("instr p%0d %h", p, addr), bus.o_instr[p]);
  endtask

  // Wait (bounded) for a request, check its address, answer with one line.
  task automatic refill(input logic [31:0] exp_addr);
    int k = 0;
    while (!bus.o_mem_read && k < 16) begin
      cyc();
      k++;
    end
    expect_now($sformatf("mem_read for %h", exp_addr), {31'b0, bus.o_mem_read}, 32'd1);
    expect_now("mem_address", bus.o_mem_address, exp_addr);
    if (!bus.o_mem_read) return;
    bus.i_mem_data  = mem_line(exp_addr);
    bus.i_mem_ready = 1'b1;
    cyc();
    bus.i_mem_ready = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.i_read      = '0;
    bus.i_address   = '0;
    bus.i_flush     = 1'b0;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    @(negedge clock);

    // Reset: outputs quiet even with reads requested.
    bus.i_read = '1;
    bus.i_address[0] = 32'h104;
    bus.i_address[1] = 32'h200;
    cyc(2);
    #1;
    expect_now("rst hit", 32'(bus.o_hit), 32'd0);
    expect_now("rst instr0", bus.o_instr[0], 32'd0);
    expect_now("rst instr1", bus.o_instr[1], 32'd0);
    expect_now("rst mem_read", {31'b0, bus.o_mem_read}, 32'd0);
    expect_now("rst mem_address", bus.o_mem_address, 32'd0);
    expect_now("rst miss_count", bus.o_miss_count, 32'd0);
    idle_inputs();
    reset = 1'b1;
    cyc();

    // Cold miss on 0x104.
    lookup(0, 32'h104, 1'b0);
    cyc();
    expect_now("cold mem_read", {31'b0, bus.o_mem_read}, 32'd1);
    expect_now("cold mem_address", bus.o_mem_address, 32'h100);
    expect_now("cold miss_count", bus.o_miss_count, 32'd1);
    cyc(2);
    expect_now("cold held address", bus.o_mem_address, 32'h100);
    expect_now("cold no recount", bus.o_miss_count, 32'd1);
    refill(32'h100);
    lookup(0, 32'h104, 1'b1);
    expect_now("cold count after", bus.o_miss_count, 32'd1);
    expect_now("cold idle mem_read", {31'b0, bus.o_mem_read}, 32'd0);

    // Ready strobe while idle is ignored.
    bus.i_mem_data  = {LINE_WORDS{$urandom_range(32'hFFFF_FFFF, 0)}};
    bus.i_mem_ready = 1'b1;
    cyc();
    bus.i_mem_ready = 1'b0;
    lookup(0, 32'h104, 1'b1);
    expect_now("idle ready mem_read", {31'b0, bus.o_mem_read}, 32'd0);

    // Eviction in set 0: 0x300 replaces the 0x100 line.
    lookup(0, 32'h200, 1'b0);
    refill(32'h200);
    lookup(0, 32'h300, 1'b0);
    refill(32'h300);
    lookup(0, 32'h200, 1'b1);
    lookup(0, 32'h300, 1'b1);
    lookup(0, 32'h100, 1'b0);
    bus.i_read = '0;
    cyc();
    expect_now("evict miss_count", bus.o_miss_count, 32'd3);

    // Dual miss on different lines: port 0 served first.
    do_reset();
    lookup(0, 32'h100, 1'b0);
    lookup(1, 32'h400, 1'b0);
    refill(32'h100);
    refill(32'h400);
    lookup(0, 32'h100, 1'b1);
    lookup(1, 32'h400, 1'b1);
    expect_now("dual miss_count", bus.o_miss_count, 32'd2);

    // Same-line dual miss: a single refill.
    do_reset();
    lookup(0, 32'h104, 1'b0);
    lookup(1, 32'h11C, 1'b0);
    refill(32'h100);
    lookup(0, 32'h104, 1'b1);
    lookup(1, 32'h11C, 1'b1);
    cyc(2);
    expect_now("same mem_read", {31'b0, bus.o_mem_read}, 32'd0);
    expect_now("same miss_count", bus.o_miss_count, 32'd1);

    // Flush while the refill is pending: request holds, line dropped.
    do_reset();
    lookup(0, 32'h104, 1'b0);
    cyc();
    bus.i_flush = 1'b1;
    cyc();
    bus.i_flush = 1'b0;
    bus.i_read  = '0;
    cyc();
    expect_now("flush held mem_read", {31'b0, bus.o_mem_read}, 32'd1);
    expect_now("flush held address", bus.o_mem_address, 32'h100);
    refill(32'h100);
    expect_now("flush back idle", {31'b0, bus.o_mem_read}, 32'd0);
    lookup(0, 32'h104, 1'b0);
    cyc();
    expect_now("flush new refill", {31'b0, bus.o_mem_read}, 32'd1);
    expect_now("flush miss_count", bus.o_miss_count, 32'd2);
    refill(32'h100);
    lookup(0, 32'h104, 1'b1);

    // Flush and fill on the same edge: flush wins.
    lookup(1, 32'h200, 1'b0);
    cyc();
    bus.i_read[1]   = 1'b0;
    bus.i_mem_data  = mem_line(32'h200);
    bus.i_mem_ready = 1'b1;
    bus.i_flush     = 1'b1;
    cyc();
    bus.i_mem_ready = 1'b0;
    bus.i_flush     = 1'b0;
    lookup(1, 32'h200, 1'b0);
    lookup(0, 32'h104, 1'b0);
    bus.i_read = '0;
    cyc();

    // Reset during FETCH abandons the refill.
    do_reset();
    lookup(0, 32'h104, 1'b0);
    refill(32'h100);
    lookup(0, 32'h104, 1'b1);
    lookup(1, 32'h300, 1'b0);
    cyc();
    expect_now("midrst fetching", {31'b0, bus.o_mem_read}, 32'd1);
    reset = 1'b0;
    #1;
    expect_now("midrst hit gated", 32'(bus.o_hit), 32'd0);
    expect_now("midrst instr gated", bus.o_instr[0], 32'd0);
    cyc();
    expect_now("midrst mem_read", {31'b0, bus.o_mem_read}, 32'd0);
    expect_now("midrst mem_address", bus.o_mem_address, 32'd0);
    expect_now("midrst miss_count", bus.o_miss_count, 32'd0);
    reset = 1'b1;
    lookup(0, 32'h104, 1'b0);
    lookup(1, 32'h300, 1'b0);
    bus.i_read = '0;
    cyc();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
